// File: rtl/video_pkg.sv
// Shared types and helpers for the video fetch path: FSM state encoding,
// Wishbone cycle-type codes and frame sizing.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic int frame_words(input int hdisp, input int vdisp);
        return hdisp * vdisp;
    endfunction

endpackage

// File: rtl/pixel_fetch_fsm_edge_pulse.sv
// Rising-edge detector: one-cycle pulse for each 0->1 transition of d_i.
// Latency: pulse appears one clock after the edge; no backpressure.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic d_q;
    logic pulse_q;
    logic pulse_d;

    assign pulse_d = d_i & ~d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            d_q     <= d_i;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pixel_fetch_fsm.sv
// Wishbone read master streaming a frame of pixel words into the pixel FIFO (burst CTI via PIXEL_FETCH_BURST_EN).
// Latency: acked word written to the FIFO combinationally; fill_set/frame_wrap one clock late.
// Backpressure: stops requesting once the FIFO is almost full, resumes when space returns.
module pixel_fetch_fsm
    import video_pkg::*;
#(
    parameter int                    HDISP      = 800,
    parameter int                    VDISP      = 480,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack,
    input  logic                    fifo_wfull,
    input  logic                    fifo_walmost_full,
    output logic                    fifo_write,
    output logic [DATA_WIDTH-1:0]   fifo_wdata,
    output logic                    fill_set,
    output logic                    frame_wrap
`ifdef PIXEL_FETCH_BURST_EN
    ,
    output logic [2:0]              wb_cti,
    output logic [1:0]              wb_bte
`endif
);

    localparam int FRAME_WORDS = frame_words(HDISP, VDISP);
    localparam int CNT_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    fetch_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wrap_q, wrap_d;
    logic                    last_pixel;

    assign last_pixel = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            adr_q   <= BASE_ADDR;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        wb_cyc     = 1'b0;
        wb_stb     = 1'b0;
        fifo_write = 1'b0;
        fifo_wdata = '0;
        case (state_q)
            IDLE: begin
                state_d = fifo_walmost_full ? WAIT : REQ;
            end
            REQ: begin
                wb_cyc = 1'b1;
                wb_stb = 1'b1;
                if (wb_ack) begin
                    fifo_write = 1'b1;
                    fifo_wdata = wb_dat_i;
                    // The last pixel's ack rewinds to the frame base; wrap and
                    // almost-full may coincide and both take effect.
                    if (last_pixel) begin
                        cnt_d  = '0;
                        adr_d  = BASE_ADDR;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        adr_d = adr_q + ADR_STEP;
                    end
                    if (fifo_walmost_full) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!fifo_walmost_full) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wb_we      = 1'b0;
    assign wb_sel     = '1;
    assign wb_adr     = adr_q;
    assign frame_wrap = wrap_q;

`ifdef PIXEL_FETCH_BURST_EN
    always_comb begin
        wb_cti = CTI_CLASSIC;
        if (state_q == REQ) begin
            wb_cti = (fifo_walmost_full || last_pixel) ? CTI_EOB : CTI_INCR;
        end
    end

    assign wb_bte = 2'b00;
`endif

    edge_pulse u_fill_edge (
        .clk     (clk),
        .rst_n   (reset_n),
        .d_i     (fifo_wfull),
        .pulse_o (fill_set)
    );

endmodule

// File: tb/tb_pixel_fetch_fsm.sv
// Directed bench for pixel_fetch_fsm on a 4x2 frame with hand-computed expectations.
module tb_pixel_fetch_fsm;

    logic        clk;
    logic        reset_n;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        fifo_wfull;
    logic        fifo_walmost_full;
    logic        fifo_write;
    logic [31:0] fifo_wdata;
    logic        fill_set;
    logic        frame_wrap;
`ifdef PIXEL_FETCH_BURST_EN
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
`endif

    int checks = 0;
    int errors = 0;

    pixel_fetch_fsm #(
        .HDISP      (4),
        .VDISP      (2),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .wb_cyc            (wb_cyc),
        .wb_stb            (wb_stb),
        .wb_we             (wb_we),
        .wb_sel            (wb_sel),
        .wb_adr            (wb_adr),
        .wb_dat_i          (wb_dat_i),
        .wb_ack            (wb_ack),
        .fifo_wfull        (fifo_wfull),
        .fifo_walmost_full (fifo_walmost_full),
        .fifo_write        (fifo_write),
        .fifo_wdata        (fifo_wdata),
        .fill_set          (fill_set),
        .frame_wrap        (frame_wrap)
`ifdef PIXEL_FETCH_BURST_EN
        ,
        .wb_cti            (wb_cti),
        .wb_bte            (wb_bte)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        wb_ack            = 1'b0;
        wb_dat_i          = 32'h0;
        fifo_wfull        = 1'b0;
        fifo_walmost_full = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_cyc",   32'(wb_cyc), 32'd0);
        chk("rst_stb",   32'(wb_stb), 32'd0);
        chk("rst_adr",   wb_adr, 32'h0);
        chk("rst_write", 32'(fifo_write), 32'd0);
        chk("rst_wdata", fifo_wdata, 32'h0);
        chk("rst_fill",  32'(fill_set), 32'd0);
        chk("rst_wrap",  32'(frame_wrap), 32'd0);
        chk("rst_we",    32'(wb_we), 32'd0);
        chk("rst_sel",   32'(wb_sel), 32'hF);

        // Release: one IDLE cycle, then REQ
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle_cyc", 32'(wb_cyc), 32'd0);
        @(negedge clk);

        // Frame 1: almost-full on 5th ack (adr 0x10) and on the last word
        for (int i = 0; i < 8; i++) begin
            wb_ack            = 1'b1;
            wb_dat_i          = 32'hA000_0000 + 32'(i);
            fifo_walmost_full = (i == 4) || (i == 7);
            #1;
            chk("f1_cyc",   32'(wb_cyc), 32'd1);
            chk("f1_stb",   32'(wb_stb), 32'd1);
            chk("f1_adr",   wb_adr, 32'(4 * i));
            chk("f1_write", 32'(fifo_write), 32'd1);
            chk("f1_wdata", fifo_wdata, 32'hA000_0000 + 32'(i));
            chk("f1_wrap",  32'(frame_wrap), 32'd0);
`ifdef PIXEL_FETCH_BURST_EN
            chk("f1_cti", 32'(wb_cti), ((i == 4) || (i == 7)) ? 32'b111 : 32'b010);
            chk("f1_bte", 32'(wb_bte), 32'd0);
`endif
            @(negedge clk);
            if (i == 4) begin
                wb_ack = 1'b0;
                #1;
                chk("af_cyc",   32'(wb_cyc), 32'd0);
                chk("af_stb",   32'(wb_stb), 32'd0);
                chk("af_write", 32'(fifo_write), 32'd0);
                chk("af_adr",   wb_adr, 32'h14);
                @(negedge clk); #1;
                chk("af_hold_cyc", 32'(wb_cyc), 32'd0);
                fifo_walmost_full = 1'b0;
                @(negedge clk);
            end
        end

        // Last-word ack with almost-full: wrapped and waiting
        wb_ack = 1'b0;
        #1;
        chk("w1_wrap", 32'(frame_wrap), 32'd1);
        chk("w1_adr",  wb_adr, 32'h0);
        chk("w1_cyc",  32'(wb_cyc), 32'd0);
        fifo_walmost_full = 1'b0;
        @(negedge clk); #1;
        chk("w1_wrap_once", 32'(frame_wrap), 32'd0);
        chk("w1_resume",    32'(wb_cyc), 32'd1);

        // Frame 2: back-to-back acks, counter restarted from zero
        for (int i = 0; i < 8; i++) begin
            wb_ack   = 1'b1;
            wb_dat_i = 32'h5500_0000 + 32'(i);
            #1;
            chk("f2_adr",   wb_adr, 32'(4 * i));
            chk("f2_wdata", fifo_wdata, 32'h5500_0000 + 32'(i));
            chk("f2_wrap",  32'(frame_wrap), 32'd0);
            @(negedge clk);
        end
        wb_ack = 1'b0;
        #1;
        chk("w2_wrap", 32'(frame_wrap), 32'd1);
        chk("w2_adr",  wb_adr, 32'h0);
        chk("w2_cyc",  32'(wb_cyc), 32'd1);
        @(negedge clk); #1;
        chk("w2_wrap_once", 32'(frame_wrap), 32'd0);

        // Two acks, then a stalled request, then reset mid-REQ
        wb_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
        chk("stall_cyc",   32'(wb_cyc), 32'd1);
        chk("stall_adr",   wb_adr, 32'h8);
        chk("stall_write", 32'(fifo_write), 32'd0);
        @(negedge clk); #1;
        chk("stall_hold", wb_adr, 32'h8);
        reset_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(wb_cyc), 32'd0);
        chk("arst_stb", 32'(wb_stb), 32'd0);
        chk("arst_adr", wb_adr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_idle", 32'(wb_cyc), 32'd0);
        @(negedge clk); #1;
        chk("rel_cyc", 32'(wb_cyc), 32'd1);
        chk("rel_adr", wb_adr, 32'h0);

        // Full edge held for 10 cycles: one fill_set pulse, one clock late
        fifo_walmost_full = 1'b1;
        fifo_wfull        = 1'b1;
        #1;
        chk("fill_edge", 32'(fill_set), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            chk("fill_pulse", 32'(fill_set), (k == 1) ? 32'd1 : 32'd0);
            chk("full_nowrite", 32'(fifo_write), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
